// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mult_pkg;

  localparam int WIDTH_D = 32;
  localparam int CNT_W_D = 6;
  localparam int SIGNED_STEPS = WIDTH_D;
  localparam int UNSIGNED_STEPS = WIDTH_D + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB
  } booth_op_e;

  function automatic booth_op_e booth_op(
    input logic q0,
    input logic q_1
  );
    booth_op_e op;
    unique case ({q0, q_1})
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A,
// then arithmetic right shift of {A,Q,q_1}.
module booth_step
  import mult_pkg::*;
#(
  parameter int AW = 33,
  parameter int QW = 32
) (
  input  logic [AW-1:0] a_i,
  input  logic [QW-1:0] q_i,
  input  logic          q_1_i,
  input  logic [AW-1:0] m_i,
  output logic [AW-1:0] a_o,
  output logic [QW-1:0] q_o,
  output logic          q_1_o
);

  logic [AW-1:0] sum;

  always_comb begin
    sum = a_i;
    unique case (booth_op(q_i[0], q_1_i))
      OP_ADD:  sum = a_i + m_i;
      OP_SUB:  sum = a_i - m_i;
      default: sum = a_i;
    endcase
  end

  assign a_o   = {sum[AW-1], sum[AW-1:1]};
  assign q_o   = {sum[0], q_i[QW-1:1]};
  assign q_1_o = q_i[0];

endmodule

// File: rtl/booth_mult.sv
// Multi-cycle signed Booth multiplier writing HI/LO (MIPS MULT).
// Define MULTU_EN to add the isUnsigned port and MULTU support.
module booth_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             multCtrl,
`ifdef MULTU_EN
  input  logic             isUnsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

`ifdef MULTU_EN
  localparam int QW = WIDTH + 1;
`else
  localparam int QW = WIDTH;
`endif

  state_e           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [QW-1:0]    q_q, q_d;
  logic             q1_q, q1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             uns_q, uns_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   a_n;
  logic [QW-1:0]    q_n;
  logic             q1_n;
  logic             ld_uns;
  logic [CNT_W-1:0] last_cnt;
  logic [WIDTH-1:0] res_hi, res_lo;

  booth_step #(
    .AW(WIDTH + 1),
    .QW(QW)
  ) u_step (
    .a_i  (a_q),
    .q_i  (q_q),
    .q_1_i(q1_q),
    .m_i  (m_q),
    .a_o  (a_n),
    .q_o  (q_n),
    .q_1_o(q1_n)
  );

`ifdef MULTU_EN
  assign ld_uns = isUnsigned;

  // Unsigned runs one extra step, so the product sits one bit lower.
  always_comb begin
    if (uns_q) begin
      res_hi = {a_q[WIDTH-2:0], q_q[WIDTH]};
      res_lo = q_q[WIDTH-1:0];
    end else begin
      res_hi = a_q[WIDTH-1:0];
      res_lo = q_q[WIDTH:1];
    end
  end
`else
  assign ld_uns = 1'b0;
  assign res_hi = a_q[WIDTH-1:0];
  assign res_lo = q_q;
`endif

  assign last_cnt = uns_q ? CNT_W'(WIDTH) : CNT_W'(WIDTH - 1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    uns_d   = uns_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (multCtrl) begin
      a_d     = '0;
      q_d     = QW'(srcB);
      q1_d    = 1'b0;
      m_d     = ld_uns ? {1'b0, srcA} : {srcA[WIDTH-1], srcA};
      cnt_d   = '0;
      uns_d   = ld_uns;
      busy_d  = 1'b1;
      state_d = RUN;
    end else begin
      unique case (state_q)
        IDLE: ;
        RUN: begin
          a_d   = a_n;
          q_d   = q_n;
          q1_d  = q1_n;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == last_cnt) state_d = FINISH;
        end
        FINISH: begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      uns_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      uns_q   <= uns_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_booth_mult.sv
// Scoreboard bench for booth_mult: random and directed products
// against an arithmetic reference, with abort/reset/hold cases.
module tb_booth_mult;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] srcA, srcB;
  logic        multCtrl;
  logic        uns;
  logic        busy, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  booth_mult dut (
    .clk       (clk),
    .reset     (reset),
    .srcA      (srcA),
    .srcB      (srcB),
    .multCtrl  (multCtrl),
`ifdef MULTU_EN
    .isUnsigned(uns),
`endif
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  typedef struct {
    logic [63:0] prod;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_hi = '0, last_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        u
  );
    longint sa, sb2;
    if (u) return {32'd0, a} * {32'd0, b};
    sa  = $signed(a);
    sb2 = $signed(b);
    return sa * sb2;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got hi=%h lo=%h, no result due",
                 hi, lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("product", {hi, lo}, e.prod);
        chk("latency", 64'(cyc), 64'(e.at));
        chk("busy_at_done", 64'(busy), 64'd0);
        last_hi = e.prod[63:32];
        last_lo = e.prod[31:0];
      end
    end
  end

  task automatic load(input logic [31:0] a, input logic [31:0] b,
                      input logic u, input int hold, input bit push,
                      output int edge_no);
    int lat;
`ifdef MULTU_EN
    lat = u ? 34 : 33;
`else
    u   = 1'b0;
    lat = 33;
`endif
    @(negedge clk);
    srcA     = a;
    srcB     = b;
    uns      = u;
    multCtrl = 1'b1;
    repeat (hold - 1) @(negedge clk);
    edge_no = cyc + 1;
    if (push) sb.push_back('{model(a, b, u), edge_no + lat});
    @(negedge clk);
    multCtrl = 1'b0;
    srcA     = $urandom;
    srcB     = $urandom;
    uns      = 1'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results still pending", sb.size());
      sb.delete();
    end
    @(negedge clk);
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  logic [31:0] da[6] = '{32'd7, 32'hFFFF_FFF9, 32'h8000_0000,
                         32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0};
  logic [31:0] db[6] = '{32'd3, 32'd3, 32'h8000_0000,
                         32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};

  initial begin
    int e0;
    reset    = 1'b1;
    multCtrl = 1'b0;
    srcA     = '0;
    srcB     = '0;
    uns      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    reset = 1'b0;

    // Busy must stay high over the whole signed run.
    load(32'd7, 32'd3, 1'b0, 1, 1'b1, e0);
    for (int i = 0; i < 31; i++) begin
      chk("busy_run", 64'(busy), 64'd1);
      @(negedge clk);
    end
    wait_idle();

    foreach (da[i]) begin
      load(da[i], db[i], 1'b0, 1, 1'b1, e0);
      wait_idle();
    end

`ifdef MULTU_EN
    load(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1, 1'b1, e0);
    wait_idle();
    load(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, 1'b1, e0);
    wait_idle();
`endif

    // Abort: second load restarts, prior hi/lo held meanwhile.
    load(32'd5, 32'd5, 1'b0, 1, 1'b0, e0);
    repeat (8) @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd1);
    chk("abort_held", {hi, lo}, {last_hi, last_lo});
    load(32'd6, 32'hFFFF_FFFE, 1'b0, 1, 1'b1, e0);
    repeat (20) @(negedge clk);
    chk("run_held", {hi, lo}, 64'h0000_0000_0000_0000 | {last_hi, last_lo});
    wait_idle();

    // multCtrl held high: result timed from the last load edge.
    load(32'h0001_0003, 32'hFFF0_0001, 1'b0, 3, 1'b1, e0);
    wait_idle();

    // Reset mid-operation clears outputs and suppresses done.
    load(32'd7, 32'd3, 1'b0, 1, 1'b1, e0);
    wait_idle();
    load(32'd9, 32'd9, 1'b0, 1, 1'b0, e0);
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_hilo", {hi, lo}, 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    last_hi = '0;
    last_lo = '0;
    repeat (40) @(negedge clk);
    chk("postreset_hilo", {hi, lo}, 64'd0);

    for (int i = 0; i < 24; i++) begin
      load($urandom, $urandom, 1'($urandom), 1, 1'b1, e0);
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_mult.md
Name: booth_mult

Overview:
- Multi-cycle signed multiplier (MIPS MULT semantics); the companion of the sequential divider in the same datapath.
- Loads two 32-bit operands on an init strobe and runs one radix-2 Booth step per cycle.
- Writes the 64-bit product to hi (upper word) and lo (lower word) for the HI/LO register path.
- Holds hi/lo stable between operations, so the control unit reads them exactly as it reads divider results.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH+1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk only.
- srcA  input  WIDTH  multiplicand; sampled only on the load edge.
- srcB  input  WIDTH  multiplier; sampled only on the load edge.
- multCtrl  input  1  MultInit; 1 at a posedge loads srcA/srcB and starts an operation.
- busy  output  1  high from the load edge until the result edge.
- done  output  1  one-cycle pulse coincident with new hi/lo.
- hi  output  WIDTH  product[2*WIDTH-1:WIDTH].
- lo  output  WIDTH  product[WIDTH-1:0].
- (MULTU_EN only) isUnsigned  input  1  sampled with multCtrl; 1 selects MULTU.

Behaviour:
- Reset (synchronous, active-high): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset has priority over multCtrl.
- Internal state:
  - M: multiplicand, sign-extended to WIDTH+1 bits.
  - Accumulator A: WIDTH+1 bits.
  - Q: multiplier, WIDTH bits.
  - q_1: extra Booth bit.
  - The (WIDTH+1)-bit A makes M = -2^31 add/subtract overflow-free.
- States: IDLE, RUN, FINISH.
- Load edge E0 (multCtrl=1, any state): A=0, Q=srcB, q_1=0, M=sext(srcA), counter=0, busy=1, done=0, state=RUN.
- RUN, each edge, when multCtrl=0:
  - {Q[0],q_1} = 01: A=A+M.
  - {Q[0],q_1} = 10: A=A-M.
  - 00 or 11: no add.
  - Then arithmetic right shift of {A,Q,q_1} by 1; counter++.
  - After WIDTH steps (edge E32 for WIDTH=32): state=FINISH.
- FINISH edge E33: {hi,lo}={A[WIDTH-1:0],Q}, done=1, busy=0, state=IDLE.
- Latency: 33 cycles from the load edge to the result edge. done deasserts on the next edge (E34) unless a new load occurs.
- hi/lo change only on a FINISH edge or on reset; they hold the prior result during RUN.
- multCtrl during RUN/FINISH aborts the current operation and restarts with new operands; the aborted result is never written and no done pulse occurs for it.
- multCtrl held high across several edges: reloads on every edge; computation starts on the first edge with multCtrl=0.
- Reset mid-operation: abort, all outputs return to reset values.
- No overflow flag: the full 2*WIDTH-bit product is always exact.

Optional Feature:
- Macro MULTU_EN.
- Defined:
  - Port isUnsigned exists.
  - When isUnsigned=1 at load: M is zero-extended, and the multiplier is zero-extended to WIDTH+1 bits (Q widened by 1).
  - WIDTH+1 Booth steps run, so unsigned latency is 34 cycles.
  - Result = unsigned product.
  - When isUnsigned=0: behaviour is identical to the undefined case.
- Undefined: no isUnsigned port; signed only; 33-cycle latency.

Decomposition:
- Package mult_pkg:
  - State enum {IDLE, RUN, FINISH}.
  - Booth operation encoding {NOP, ADD, SUB}.
  - Default WIDTH/CNT_W constants.
  - SIGNED_STEPS=WIDTH, UNSIGNED_STEPS=WIDTH+1.
- Sub-module booth_step (combinational):
  - Inputs: A, Q, q_1, M.
  - Outputs: next A, Q, q_1 (add/sub plus arithmetic shift).
  - Instantiated once inside booth_mult and unit-testable alone.

Test Plan:
- srcA=7, srcB=3, pulse multCtrl -> busy 33 cycles; done pulses with hi=0x00000000, lo=0x00000015.
- srcA=-7 (0xFFFFFFF9), srcB=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- srcA=srcB=0x80000000 -> hi=0x40000000, lo=0x00000000. srcA=srcB=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
- Start 5*5, re-pulse multCtrl at cycle 10 with 6*(-2) -> exactly one done, 33 cycles after the second load: hi=0xFFFFFFFF, lo=0xFFFFFFF4; hi/lo keep the prior values until then.
- Previous result 7*3 held; start 9*9 and assert reset at cycle 15 -> hi=lo=0, busy=0, done never pulses.
- MULTU_EN: isUnsigned=1, srcA=srcB=0xFFFFFFFF -> done at cycle 34, hi=0xFFFFFFFE, lo=0x00000001. Same operands with isUnsigned=0 -> hi=0, lo=1 at cycle 33.
